mpmc10_resp_strip_acc: RTL

- Receive-side companion to the request strip counter in the mpmc10 controller.
- Counts read-data strips returned by the DDR app interface (rd_data_valid) against the programmed num_strips.
- Packs the strips into LINE_STRIPS-wide lines and hands each completed line to the port read-return path through a single holding register with a valid/ack handshake.
- Flags stray or overrun data.

---
 rtl/mpmc10_resp_strip_acc.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mpmc10_resp_strip_acc.sv
// mpmc10_resp_strip_acc: counts read-data strips returned by the DDR app
// interface against the programmed transfer length. It packs the strips into
// LINE_STRIPS-wide lines and hands each finished line to the port read-return
// path through one holding register with a valid/ack handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse arming a transfer (only honoured in IDLE)
//   abort           discard the transfer in progress
//   num_strips      index of the last strip (transfer is num_strips+1 strips)
//   rd_data_valid   app read-data strip valid (no back-pressure)
//   rd_data         app read-data strip
//   line_ack        consumer has taken line_o
//   err_clr         clears the sticky error flags
//   line_valid      line_o / line_idx hold a line
//   line_o          line data, slot 0 in the LSBs
//   line_idx        strip index of slot 0 of line_o
//   strip_cnt       strips received in the current or last transfer
//   busy            collecting a transfer
//   done            one-cycle pulse with the final line of a transfer
//   ovf_err         sticky: strip arrived while not collecting
//   ovr_err         sticky: a line completed while the holding register was full
module mpmc10_resp_strip_acc #(
  parameter int unsigned STRIP_W     = 128,
  parameter int unsigned LINE_STRIPS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [5:0]                     num_strips,
  input  logic                           rd_data_valid,
  input  logic [STRIP_W-1:0]             rd_data,
  input  logic                           line_ack,
  input  logic                           err_clr,
  output logic                           line_valid,
  output logic [LINE_STRIPS*STRIP_W-1:0] line_o,
  output logic [5:0]                     line_idx,
  output logic [6:0]                     strip_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf_err,
  output logic                           ovr_err
);

  localparam int unsigned LINE_W = LINE_STRIPS * STRIP_W;
  localparam int unsigned SLOT_W = (LINE_STRIPS > 1) ? $clog2(LINE_STRIPS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(LINE_STRIPS - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          last_q, last_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LINE_W-1:0]   acc_q, acc_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [5:0]          idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                ovr_q, ovr_d;

  logic                strip_in;
  logic                strip_last;
  logic                line_done;
  logic                stray;
  logic                hold_free;
  logic [LINE_W-1:0]   acc_wr;

  // abort masks every strip-related event in the same cycle
  assign strip_in   = rd_data_valid && !abort && (state_q == COLLECT);
  assign stray      = rd_data_valid && !abort && (state_q == IDLE);
  assign strip_last = strip_in && (cnt_q == 7'(last_q));
  assign line_done  = strip_in && ((slot_q == SLOT_MAX) || (cnt_q == 7'(last_q)));
  // an ack in the completion cycle frees the register for the new line
  assign hold_free  = !valid_q || line_ack;

  // accumulator with the incoming strip placed in the current slot
  always_comb begin : acc_merge
    acc_wr = acc_q;
    for (int unsigned s = 0; s < LINE_STRIPS; s++) begin
      if (slot_q == SLOT_W'(s)) begin
        acc_wr[s*STRIP_W +: STRIP_W] = rd_data;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin : next_state
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)      state_d = COLLECT;
        COLLECT: if (strip_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath and output next-values
  always_comb begin : outputs_next
    last_d  = last_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    acc_d   = acc_q;
    line_d  = line_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = strip_last;
    busy_d  = (state_d == COLLECT);
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;

    if (abort) begin
      acc_d  = '0;
      slot_d = '0;
    end else if ((state_q == IDLE) && start) begin
      last_d = num_strips;
      cnt_d  = '0;
      slot_d = '0;
      acc_d  = '0;
    end else if (strip_in) begin
      cnt_d = cnt_q + 7'd1;
      if (line_done) begin
        acc_d  = '0;
        slot_d = '0;
      end else begin
        acc_d  = acc_wr;
        slot_d = slot_q + 1'b1;
      end
    end

    if (valid_q && line_ack) begin
      valid_d = 1'b0;
    end

    if (line_done) begin
      if (hold_free) begin
        line_d  = acc_wr;
        idx_d   = 6'(cnt_q - 7'(slot_q));
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // clear first so a same-cycle error wins
    if (err_clr) begin
      ovf_d = 1'b0;
      if (!(line_done && !hold_free)) begin
        ovr_d = 1'b0;
      end
    end
    if (stray) begin
      ovf_d = 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      acc_q   <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      acc_q   <= acc_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign line_valid = valid_q;
  assign line_o     = line_q;
  assign line_idx   = idx_q;
  assign strip_cnt  = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf_err    = ovf_q;
  assign ovr_err    = ovr_q;

endmodule
